// File: rtl/cal_arbiter_pkg.sv
// cal_arbiter_pkg: owner select codes, arbiter state encodings and default parameters
// shared by the arbiter, its burst counter and the downstream mux encoder.
`default_nettype none

package cal_arbiter_pkg;

  localparam logic ARB_CPU = 1'b0;
  localparam logic ARB_ACC = 1'b1;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_CPU  = 2'd1,
    ARB_ST_ACC  = 2'd2
  } arb_state_t;

  localparam int ACC_MAX_BURST_DEF = 16;
  localparam int CNT_W_DEF         = 5;

endpackage

`default_nettype wire

// File: rtl/cal_arb_burst_cnt.sv
// cal_arb_burst_cnt: clear/enable saturating counter whose terminal count flags
// that the ACC has held the port for TC_VAL+1 cycles.
`default_nettype none

module cal_arb_burst_cnt #(
  parameter int CNT_W  = 5,
  parameter int TC_VAL = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // >= rather than == so a CPU request arriving after saturation still forces a yield
  assign o_tc = (r_cnt >= CNT_W'(TC_VAL));

endmodule

`default_nettype wire

// File: rtl/cal_arbiter.sv
// cal_arbiter: CPU/ACC data-port arbiter with alternating priority and one-cycle turnaround.
// Define CAL_ARB_BURST_LIMIT_EN to enable the ACC burst limit and the acc_yield pulse.
`default_nettype none

module cal_arbiter
  import cal_arbiter_pkg::*;
#(
  parameter int ACC_MAX_BURST = ACC_MAX_BURST_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic acc_req,
  output logic cpu_gnt,
  output logic acc_gnt,
  output logic arb_res,
  output logic busy,
  output logic acc_yield
);

  if ((ACC_MAX_BURST < 2) || (ACC_MAX_BURST > (1 << CNT_W))) begin : g_param_chk
    $error("cal_arbiter: ACC_MAX_BURST out of range for CNT_W");
  end

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_owner;
  logic       w_last_owner_nxt;
  logic       r_acc_yield;
  logic       w_acc_yield_nxt;
  logic       w_force_yield;

`ifdef CAL_ARB_BURST_LIMIT_EN
  logic w_burst_tc;

  cal_arb_burst_cnt #(
    .CNT_W  (CNT_W),
    .TC_VAL (ACC_MAX_BURST - 1)
  ) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state != ARB_ST_ACC),
    .i_en  (r_state == ARB_ST_ACC),
    .o_tc  (w_burst_tc)
  );

  assign w_force_yield = w_burst_tc & cpu_req;
`else
  assign w_force_yield = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_acc_yield_nxt  = 1'b0;
    case (r_state)
      ARB_ST_IDLE: begin
        // on contention the side that did not own the port last wins
        if (cpu_req && (!acc_req || (r_last_owner == ARB_ACC))) begin
          w_state_nxt = ARB_ST_CPU;
        end else if (acc_req) begin
          w_state_nxt = ARB_ST_ACC;
        end
      end
      ARB_ST_CPU: begin
        if (!cpu_req) begin
          w_state_nxt      = ARB_ST_IDLE;
          w_last_owner_nxt = ARB_CPU;
        end
      end
      ARB_ST_ACC: begin
        if (!acc_req) begin
          w_state_nxt      = ARB_ST_IDLE;
          w_last_owner_nxt = ARB_ACC;
        end else if (w_force_yield) begin
          w_state_nxt      = ARB_ST_IDLE;
          w_last_owner_nxt = ARB_ACC;
          w_acc_yield_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_ST_IDLE;
      r_last_owner <= ARB_ACC;
      r_acc_yield  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_acc_yield  <= w_acc_yield_nxt;
    end
  end

  assign cpu_gnt   = (r_state == ARB_ST_CPU);
  assign acc_gnt   = (r_state == ARB_ST_ACC);
  assign arb_res   = (r_state == ARB_ST_ACC) ? ARB_ACC : ARB_CPU;
  assign busy      = (r_state != ARB_ST_IDLE);
  assign acc_yield = r_acc_yield;

endmodule

`default_nettype wire

// File: tb/tb_cal_arbiter.sv
// tb_cal_arbiter: directed vectors plus a random-request invariant sweep for cal_arbiter.
// Expected values adapt to CAL_ARB_BURST_LIMIT_EN (burst limit of 4 when defined).
`default_nettype none

module tb_cal_arbiter;

  // output vector order: {cpu_gnt, acc_gnt, arb_res, busy, acc_yield}
  localparam logic [4:0] c_IDLE = 5'b00000;
  localparam logic [4:0] c_CPU  = 5'b10010;
  localparam logic [4:0] c_ACC  = 5'b01110;
  localparam logic [4:0] c_YLD  = 5'b00001;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req;
  logic acc_req;
  logic cpu_gnt;
  logic acc_gnt;
  logic arb_res;
  logic busy;
  logic acc_yield;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  cal_arbiter #(
    .ACC_MAX_BURST (4),
    .CNT_W         (5)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .acc_req   (acc_req),
    .cpu_gnt   (cpu_gnt),
    .acc_gnt   (acc_gnt),
    .arb_res   (arb_res),
    .busy      (busy),
    .acc_yield (acc_yield)
  );

  function automatic logic [4:0] outs();
    return {cpu_gnt, acc_gnt, arb_res, busy, acc_yield};
  endfunction

  task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic a);
    cpu_req = c;
    acc_req = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    acc_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic c_r;
  logic a_r;
  logic prev_c;
  logic prev_a;

  initial begin
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    acc_req = 1'b0;
    #2;
    chk_eq("reset_async", 8'(outs()), 8'(c_IDLE));
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_held", 8'(outs()), 8'(c_IDLE));
    rst_n = 1'b1;

    // CPU alone: 1-cycle grant and release latency
    step(1'b0, 1'b0);
    chk_eq("idle_no_req", 8'(outs()), 8'(c_IDLE));
    step(1'b1, 1'b0);
    chk_eq("cpu_grant", 8'(outs()), 8'(c_CPU));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_eq("cpu_hold", 8'(outs()), 8'(c_CPU));
    step(1'b0, 1'b0);
    chk_eq("cpu_release", 8'(outs()), 8'(c_IDLE));

    // simultaneous requests after reset: CPU first, then alternate
    do_reset();
    step(1'b1, 1'b1);
    chk_eq("both_first_cpu", 8'(outs()), 8'(c_CPU));
    step(1'b1, 1'b1);
    chk_eq("acc_no_preempt", 8'(outs()), 8'(c_CPU));
    step(1'b0, 1'b1);
    chk_eq("turnaround_c2a", 8'(outs()), 8'(c_IDLE));
    step(1'b0, 1'b1);
    chk_eq("acc_grant", 8'(outs()), 8'(c_ACC));
    step(1'b0, 1'b0);
    chk_eq("acc_release", 8'(outs()), 8'(c_IDLE));
    step(1'b1, 1'b1);
    chk_eq("both_after_acc", 8'(outs()), 8'(c_CPU));

    // CPU drops for one cycle and re-raises: ACC now wins
    step(1'b0, 1'b1);
    chk_eq("cpu_blip_idle", 8'(outs()), 8'(c_IDLE));
    step(1'b1, 1'b1);
    chk_eq("cpu_blip_loses", 8'(outs()), 8'(c_ACC));
    step(1'b0, 1'b0);
    chk_eq("blip_release", 8'(outs()), 8'(c_IDLE));

    // ACC burst with CPU waiting
    step(1'b0, 1'b1);
    chk_eq("burst_acc_c1", 8'(outs()), 8'(c_ACC));
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_eq("burst_acc_c3", 8'(outs()), 8'(c_ACC));
    step(1'b1, 1'b1);
    chk_eq("burst_acc_c4", 8'(outs()), 8'(c_ACC));
`ifdef CAL_ARB_BURST_LIMIT_EN
    step(1'b1, 1'b1);
    chk_eq("burst_yield", 8'(outs()), 8'(c_YLD));
    step(1'b1, 1'b1);
    chk_eq("burst_cpu_after", 8'(outs()), 8'(c_CPU));
    step(1'b1, 1'b1);
    chk_eq("yield_one_pulse", 8'(outs()), 8'(c_CPU));
    step(1'b0, 1'b1);
    chk_eq("post_yield_idle", 8'(outs()), 8'(c_IDLE));
`else
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      chk_eq("burst_no_limit", 8'(outs()), 8'(c_ACC));
    end
    step(1'b1, 1'b0);
    chk_eq("burst_acc_drop", 8'(outs()), 8'(c_IDLE));
    step(1'b1, 1'b0);
    chk_eq("burst_cpu_after", 8'(outs()), 8'(c_CPU));
    step(1'b0, 1'b1);
    chk_eq("post_burst_idle", 8'(outs()), 8'(c_IDLE));
`endif
    step(1'b0, 1'b1);
    chk_eq("acc_before_rst", 8'(outs()), 8'(c_ACC));

    // asynchronous reset mid-burst, then re-grant one cycle after release
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rst_mid_burst", 8'(outs()), 8'(c_IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_eq("rst_released", 8'(outs()), 8'(c_IDLE));
    step(1'b0, 1'b1);
    chk_eq("acc_after_rst", 8'(outs()), 8'(c_ACC));
    step(1'b0, 1'b0);

    // random requests: grant exclusivity, turnaround and output consistency
    c_r = 1'b0;
    a_r = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      prev_c = cpu_gnt;
      prev_a = acc_gnt;
      if ($urandom_range(0, 7) == 0) c_r = ~c_r;
      if ($urandom_range(0, 7) == 0) a_r = ~a_r;
      step(c_r, a_r);
      chk_eq("stress_excl", 8'(cpu_gnt & acc_gnt), 8'd0);
      chk_eq("stress_turn", 8'((prev_c & acc_gnt) | (prev_a & cpu_gnt)), 8'd0);
      chk_eq("stress_busy", 8'(busy), 8'(cpu_gnt | acc_gnt));
      chk_eq("stress_arb", 8'(arb_res), 8'(acc_gnt));
`ifndef CAL_ARB_BURST_LIMIT_EN
      chk_eq("stress_yield", 8'(acc_yield), 8'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
